// File: rtl/pwm_adc_multi_if.sv
// Converter-side signal bundle for pwm_adc_multi: enable/mode/comparator in,
// PWM drive and result outputs back. The controller side holds the master modport.
interface pwm_adc_multi_if #(
    parameter int unsigned DATA_W = 8
);
    logic              en_i;
    logic              mode_i;
    logic              cmp_i;
    logic              pwm_o;
    logic [DATA_W-1:0] data_o;
    logic              data_valid_o;
    logic              ovr_o;

    modport master (
        output en_i, mode_i, cmp_i,
        input  pwm_o, data_o, data_valid_o, ovr_o
    );

    modport slave (
        input  en_i, mode_i, cmp_i,
        output pwm_o, data_o, data_valid_o, ovr_o
    );
endinterface

// File: rtl/pwm_adc_multi.sv
// PWM-ramp / tracking ADC. Drives an RC-filtered PWM DAC and digitises an
// external comparator against it. Ramp mode counts the code up once per PWM
// period until the comparator trips; tracking mode steps the code +/-1 per period.
// Optional result averaging is enabled by defining PWM_ADC_AVG_EN.
module pwm_adc_multi #(
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned AVG_LOG2 = 2
) (
    input logic           clk_i,
    input logic           rst_i,
    pwm_adc_multi_if.slave bus
);
    typedef enum logic [1:0] {IDLE, RUN, HOLD, TRACK} state_t;

    state_t            state, state_d;
    logic [DATA_W-1:0] cnt, cnt_d, code, code_d, data, data_d;
    logic              s1, s2, s3, mode_q;
    logic              pwm, pwm_d, valid, valid_d, ovr, ovr_d;
    logic              fall, pend, restart, raw_hit, raw_ovr;

    // A fall in the cycle right after an over-range strobe is dropped so the
    // strobe can never be high on two consecutive cycles.
    assign fall    = s3 & ~s2 & ~valid;
    assign pend    = (cnt == '1);
    assign restart = ~bus.en_i | (bus.mode_i != mode_q);

    assign bus.pwm_o        = pwm;
    assign bus.data_o       = data;
    assign bus.data_valid_o = valid;
    assign bus.ovr_o        = ovr;

    // Comparator synchroniser plus edge-detect delay; mode history for change detect.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1     <= 1'b1;
            s2     <= 1'b1;
            s3     <= 1'b1;
            mode_q <= 1'b0;
        end else begin
            s1     <= bus.cmp_i;
            s2     <= s1;
            s3     <= s2;
            mode_q <= bus.mode_i;
        end
    end

    // Next-state, period counter, code and PWM drive.
    always_comb begin
        state_d = state;
        cnt_d   = cnt + 1'b1;
        code_d  = code;
        raw_hit = 1'b0;
        raw_ovr = 1'b0;
        case (state)
            IDLE: begin
                cnt_d   = '0;
                code_d  = '0;
                state_d = bus.mode_i ? TRACK : RUN;
            end
            RUN: begin
                if (fall) begin
                    raw_hit = 1'b1;
                    state_d = HOLD;
                end else if (pend) begin
                    if (code == '1) begin
                        raw_hit = 1'b1;
                        raw_ovr = 1'b1;
                        code_d  = '0;
                    end else begin
                        code_d = code + 1'b1;
                    end
                end
            end
            HOLD: begin
                if (pend) begin
                    code_d  = '0;
                    state_d = RUN;
                end
            end
            TRACK: begin
                if (pend) begin
                    raw_hit = 1'b1;
                    if (s2) code_d = (code == '1) ? code : code + 1'b1;
                    else    code_d = (code == '0) ? code : code - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (restart) begin
            state_d = IDLE;
            cnt_d   = '0;
            code_d  = '0;
            raw_hit = 1'b0;
            raw_ovr = 1'b0;
        end
        pwm_d = ((state_d == RUN) || (state_d == TRACK)) && (cnt < code);
    end

    // Converter state and registered outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= '0;
            code  <= '0;
            pwm   <= 1'b0;
            data  <= '0;
            valid <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            state <= state_d;
            cnt   <= cnt_d;
            code  <= code_d;
            pwm   <= pwm_d;
            data  <= data_d;
            valid <= valid_d;
            ovr   <= ovr_d;
        end
    end

`ifdef PWM_ADC_AVG_EN
    localparam int unsigned ACC_W = DATA_W + AVG_LOG2;
    localparam int unsigned GRP_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;

    logic [ACC_W-1:0] acc, acc_d, sum;
    logic [GRP_W-1:0] grp, grp_d;
    logic             ovr_acc, ovr_acc_d;

    // Accumulate raw results; publish the truncated mean once per group.
    always_comb begin
        data_d    = data;
        ovr_d     = ovr;
        valid_d   = 1'b0;
        acc_d     = acc;
        grp_d     = grp;
        ovr_acc_d = ovr_acc;
        sum       = acc + ACC_W'(code);
        if (raw_hit) begin
            if (grp == GRP_W'((1 << AVG_LOG2) - 1)) begin
                data_d    = sum[ACC_W-1:AVG_LOG2];
                ovr_d     = ovr_acc | raw_ovr;
                valid_d   = 1'b1;
                acc_d     = '0;
                grp_d     = '0;
                ovr_acc_d = 1'b0;
            end else begin
                acc_d     = sum;
                grp_d     = grp + 1'b1;
                ovr_acc_d = ovr_acc | raw_ovr;
            end
        end
        if (restart) begin
            acc_d     = '0;
            grp_d     = '0;
            ovr_acc_d = 1'b0;
        end
    end

    // Averaging accumulator, group counter and group over-range flag.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            acc     <= '0;
            grp     <= '0;
            ovr_acc <= 1'b0;
        end else begin
            acc     <= acc_d;
            grp     <= grp_d;
            ovr_acc <= ovr_acc_d;
        end
    end
`else
    // AVG_LOG2 only affects the averaging build.
    logic unused_avg_cfg;
    assign unused_avg_cfg = ^AVG_LOG2;

    // Every raw result is published directly.
    always_comb begin
        data_d  = data;
        ovr_d   = ovr;
        valid_d = 1'b0;
        if (raw_hit) begin
            data_d  = code;
            ovr_d   = raw_ovr;
            valid_d = 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_pwm_adc_multi.sv
// Directed bench for pwm_adc_multi at DATA_W=4 (16-clock PWM period).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_pwm_adc_multi;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    pwm_adc_multi_if #(.DATA_W(4)) bus ();

    pwm_adc_multi #(.DATA_W(4), .AVG_LOG2(2)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Bounded wait until the ramp/tracking code reaches k.
    task automatic wait_code(input int k);
        int n = 0;
        while (dut.code != 4'(k) && n < 400) begin
            tick(1);
            n++;
        end
        chk("wait_code", 32'(dut.code), 32'(k));
    endtask

    // Trip the comparator one cycle into the period whose code is k.
    task automatic trip(input int k, input logic exp_v, input int exp_d);
        wait_code(k);
        tick(1);
        bus.cmp_i = 1'b0;
        tick(2);
        chk("pre_strobe", 32'(bus.data_valid_o), 0);
        tick(1);
        chk("strobe", 32'(bus.data_valid_o), 32'(exp_v));
        if (exp_v) begin
            chk("trip_data", 32'(bus.data_o), 32'(exp_d));
            chk("trip_ovr", 32'(bus.ovr_o), 0);
        end
        bus.cmp_i = 1'b1;
        tick(1);
        chk("strobe_single", 32'(bus.data_valid_o), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int e;
        int strobes;
        rst        = 1'b1;
        bus.en_i   = 1'b0;
        bus.mode_i = 1'b0;
        bus.cmp_i  = 1'b1;
        tick(3);
        chk("rst_pwm", 32'(bus.pwm_o), 0);
        chk("rst_data", 32'(bus.data_o), 0);
        chk("rst_valid", 32'(bus.data_valid_o), 0);
        chk("rst_ovr", 32'(bus.ovr_o), 0);
        chk("rst_cnt", 32'(dut.cnt), 0);
        rst      = 1'b0;
        bus.en_i = 1'b1;

`ifdef PWM_ADC_AVG_EN
        trip(4, 1'b0, 0);
        trip(5, 1'b0, 0);
        trip(6, 1'b0, 0);
        trip(8, 1'b1, 5);
`else
        // Ramp trip at code 5, then discharge until the period ends.
        trip(5, 1'b1, 5);
        chk("hold_pwm", 32'(bus.pwm_o), 0);
        for (int i = 0; i < 11; i++) begin
            tick(1);
            chk("hold_pwm", 32'(bus.pwm_o), 0);
        end
        chk("restart_code", 32'(dut.code), 0);
        chk("restart_cnt", 32'(dut.cnt), 0);

        // No trip: over-range result every 16 periods.
        for (int r = 0; r < 2; r++) begin
            n = 0;
            do begin
                tick(1);
                n++;
            end while (!bus.data_valid_o && n < 300);
            chk("ovr_gap", 32'(n), 256);
            chk("ovr_data", 32'(bus.data_o), 15);
            chk("ovr_flag", 32'(bus.ovr_o), 1);
        end

        // Trip coincident with the period end at code 7.
        tick(125);
        bus.cmp_i = 1'b0;
        tick(2);
        chk("pend_pre", 32'(bus.data_valid_o), 0);
        tick(1);
        chk("pend_strobe", 32'(bus.data_valid_o), 1);
        chk("pend_data", 32'(bus.data_o), 7);
        chk("pend_ovr", 32'(bus.ovr_o), 0);
        chk("pend_noinc", 32'(dut.code), 7);
        strobes = 0;
        for (int i = 1; i <= 16; i++) begin
            tick(1);
            if (bus.data_valid_o) strobes++;
            bus.cmp_i = (i > 12) || ((i % 6) < 3);
        end
        chk("hold_strobes", 32'(strobes), 0);
        chk("hold_end_code", 32'(dut.code), 0);

        // Reset mid-ramp at code 9.
        wait_code(9);
        tick(3);
        chk("mid_pwm", 32'(bus.pwm_o), 1);
        rst = 1'b1;
        tick(1);
        chk("mrst_pwm", 32'(bus.pwm_o), 0);
        chk("mrst_cnt", 32'(dut.cnt), 0);
        chk("mrst_code", 32'(dut.code), 0);
        chk("mrst_valid", 32'(bus.data_valid_o), 0);
        chk("mrst_data", 32'(bus.data_o), 0);
        rst = 1'b0;
        trip(3, 1'b1, 3);

        // Disable mid-ramp at code 9.
        wait_code(9);
        tick(2);
        bus.en_i = 1'b0;
        tick(1);
        chk("dis_pwm", 32'(bus.pwm_o), 0);
        chk("dis_cnt", 32'(dut.cnt), 0);
        chk("dis_code", 32'(dut.code), 0);
        chk("dis_valid", 32'(bus.data_valid_o), 0);
        chk("dis_data_hold", 32'(bus.data_o), 3);
        tick(2);
        chk("dis_idle_code", 32'(dut.code), 0);
        bus.en_i = 1'b1;
        trip(3, 1'b1, 3);

        // Mode toggle mid-ramp at code 9.
        wait_code(9);
        tick(2);
        bus.mode_i = 1'b1;
        tick(1);
        chk("mode_pwm", 32'(bus.pwm_o), 0);
        chk("mode_cnt", 32'(dut.cnt), 0);
        chk("mode_code", 32'(dut.code), 0);
        chk("mode_valid", 32'(bus.data_valid_o), 0);
        bus.mode_i = 1'b0;
        tick(1);
        chk("mode_back_code", 32'(dut.code), 0);
        trip(4, 1'b1, 4);

        // Tracking: climb to full scale, saturate, then descend to zero.
        rst        = 1'b1;
        bus.mode_i = 1'b1;
        bus.cmp_i  = 1'b1;
        tick(2);
        rst = 1'b0;
        n   = 0;
        do begin
            tick(1);
            n++;
        end while (!bus.data_valid_o && n < 60);
        chk("trk_first", 32'(bus.data_valid_o), 1);
        chk("trk_data", 32'(bus.data_o), 0);
        tick(1);
        chk("trk_single", 32'(bus.data_valid_o), 0);
        tick(15);
        for (int i = 1; i < 20; i++) begin
            chk("trk_up_valid", 32'(bus.data_valid_o), 1);
            chk("trk_up_data", 32'(bus.data_o), (i > 15) ? 15 : i);
            if (i < 19) tick(16);
        end
        bus.cmp_i = 1'b0;
        for (int j = 0; j < 18; j++) begin
            tick(16);
            e = 15 - j;
            if (e < 0) e = 0;
            chk("trk_dn_valid", 32'(bus.data_valid_o), 1);
            chk("trk_dn_data", 32'(bus.data_o), 32'(e));
            chk("trk_dn_ovr", 32'(bus.ovr_o), 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/pwm_adc_multi.md
Name: pwm_adc_multi

Overview:
- Parametrised successor to the team's PWM-ramp ADC.
- Drives a PWM DAC (external RC filter) and reads an external comparator to digitise an analogue input to DATA_W bits.
- Two run-time modes:
  - ramp/single-slope: code counts up once per PWM period until the comparator trips.
  - tracking/delta: code steps ±1 per PWM period.
- Adds input synchronisation, over-range flag, a valid strobe and optional result averaging.
- Sits between the comparator pin and the DDS control logic.

Parameters:
- DATA_W, 8, code width; PWM period = 2^DATA_W clocks.
- AVG_LOG2, 2, log2 of results averaged; used only with PWM_ADC_AVG_EN.

Ports:
- clk_i  in  1  system clock
- rst_i  in  1  synchronous, active-high reset
- en_i  in  1  converter enable; low = idle
- mode_i  in  1  0 = ramp, 1 = tracking
- cmp_i  in  1  async comparator; 1 = input above filtered PWM voltage
- pwm_o  out  1  PWM DAC drive, registered
- data_o  out  DATA_W  last result
- data_valid_o  out  1  one-cycle strobe, data_o updated
- ovr_o  out  1  ramp reached full scale without a trip; valid with data_valid_o

Behaviour:
- Reset and interface:
  - One clock; reset is synchronous and active-high. On clk_i rising edge with rst_i=1, all state clears.
  - Reset values: pwm_o=0, data_o=0, data_valid_o=0, ovr_o=0, cnt=0, code=0, synchroniser=1s, state=IDLE.
- Synchroniser:
  - cmp_i passes through a 2-FF synchroniser (s1, s2) plus delay reg s3.
  - fall = s3 & ~s2; rise is not used.
- Period counter cnt:
  - DATA_W bits, free-running 0..2^DATA_W-1 while en_i=1, wraps to 0.
  - pend = (cnt == all-ones).
- PWM output:
  - pwm_o <= (cnt < code) each cycle.
  - In ramp HOLD state, pwm_o is forced 0 (discharge).
- en_i=0:
  - Next edge: state=IDLE, cnt=0, code=0, pwm_o=0.
  - data_o and ovr_o hold; no strobe.
- mode_i:
  - Sampled every cycle; a change restarts as from IDLE: cnt=0, code=0, no strobe.
  - mode_i must be stable for 2^DATA_W cycles for a valid result.
- State machine (ramp): IDLE -> RUN on en_i=1.
  - RUN, fall=1: data_o<=code, ovr_o<=0, data_valid_o=1 next cycle; -> HOLD.
  - RUN, pend=1 with code==all-ones and no fall: data_o<=all-ones, ovr_o<=1, strobe; code<=0, cnt wraps; stays RUN.
  - RUN, pend=1 otherwise: code<=code+1.
  - fall and pend in the same cycle: fall wins, no increment.
  - HOLD: ignore fall; at pend, code<=0 -> RUN (new conversion).
- Tracking mode (state TRACK):
  - At each pend: data_o<=code, strobe, ovr_o<=0.
  - Then s2=1: code<=code+1, saturating at all-ones. s2=0: code<=code-1, saturating at 0.
  - fall is ignored.
- Latency:
  - Ramp: data_valid_o rises on the 3rd rising edge, counting the edge that first samples cmp_i low.
  - Tracking: data_valid_o rises 1 cycle after pend.
- data_valid_o is never high two consecutive cycles.

Optional Feature:
- PWM_ADC_AVG_EN defined:
  - Internal accumulator, DATA_W+AVG_LOG2 bits, sums 2^AVG_LOG2 raw results.
  - On the last result of a group: data_o <= sum >> AVG_LOG2 (truncate), one strobe per group, accumulator cleared.
  - ovr_o = OR of the group's over-range flags.
  - Accumulator and group counter clear on reset, en_i=0 and mode change.
- Undefined: no accumulator; every raw result strobes directly.

Test Plan:
- DATA_W=4, ramp; cmp_i held 1, dropped to 0 one cycle after code becomes 5 -> one strobe 3 edges later, data_o=5, ovr_o=0; pwm_o=0 until period end, then ramp restarts from code 0.
- Ramp, cmp_i held 1 forever -> strobe every 16 periods, data_o=15, ovr_o=1.
- Tracking, DATA_W=4, cmp_i=1 for 20 periods then 0 -> successive data_o 0,1,...,15,15,15,15,15, then 15,14,13... down to 0 and holds 0.
- Comparator trip coincident with pend at code 7 -> data_o=7, no increment to 8; repeated falls in HOLD give no extra strobes.
- rst_i or en_i=0 asserted mid-ramp at code 9 -> next edge: pwm_o=0, cnt=0, code=0, no strobe. After release, a trip at code 3 yields data_o=3. A mode_i toggle mid-conversion behaves the same.
- PWM_ADC_AVG_EN, AVG_LOG2=2, ramp results 4,5,6,8 -> single strobe, data_o=5 (23>>2); no strobes for the first three results.
